// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the
// pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int PCTL_XLEN  = 64;
  localparam int PCTL_RAW   = 5;
  localparam int PCTL_CNT_W = 32;

  typedef enum logic [1:0] {
    PCTL_RUN   = 2'd0,
    PCTL_MWAIT = 2'd1,
    PCTL_REDIR = 2'd2
  } pctl_state_t;

  // Register match used by every forward/hazard check.
  // x0 never matches since it is hardwired to zero.
  function automatic logic rd_match(
    input logic                cen,
    input logic [PCTL_RAW-1:0] rs,
    input logic                wen,
    input logic [PCTL_RAW-1:0] rd
  );
    return cen & (rs != '0) & wen & (rd == rs);
  endfunction

endpackage

// File: rtl/pctl_fwd_unit.sv
// Operand match, forward selects and load-use
// detection for the ID stage.
module pctl_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int RAW = PCTL_RAW
) (
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs1_addr,
  input  logic [RAW-1:0] id_rs2_addr,
  input  logic           id_rs1_cen,
  input  logic           id_rs2_cen,
  input  logic [RAW-1:0] ex_rd_addr,
  input  logic           ex_rd_wen,
  input  logic           ex_mem_read,
  input  logic [RAW-1:0] ls_rd_addr,
  input  logic           ls_rd_wen,
  output logic           fwd_ex_rs1,
  output logic           fwd_ex_rs2,
  output logic           fwd_ls_rs1,
  output logic           fwd_ls_rs2,
  output logic           lu
);

  logic m1_ex;
  logic m2_ex;
  logic m1_ls;
  logic m2_ls;

  // Match each ID source against EX and LS writers.
  always_comb begin
    m1_ex = rd_match(id_rs1_cen, id_rs1_addr,
                     ex_rd_wen, ex_rd_addr);
    m2_ex = rd_match(id_rs2_cen, id_rs2_addr,
                     ex_rd_wen, ex_rd_addr);
    m1_ls = rd_match(id_rs1_cen, id_rs1_addr,
                     ls_rd_wen, ls_rd_addr);
    m2_ls = rd_match(id_rs2_cen, id_rs2_addr,
                     ls_rd_wen, ls_rd_addr);
  end

  // EX is younger so it wins; a load in EX has
  // no data yet and must stall instead.
  always_comb begin
    fwd_ex_rs1 = m1_ex & ~ex_mem_read;
    fwd_ex_rs2 = m2_ex & ~ex_mem_read;
    fwd_ls_rs1 = m1_ls & ~m1_ex;
    fwd_ls_rs2 = m2_ls & ~m2_ex;
    lu = id_valid & ex_mem_read & (m1_ex | m2_ex);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller: forwarding,
// load-use bubbles, bus freezes and trap redirects.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = PCTL_XLEN,
  parameter int RAW   = PCTL_RAW,
  parameter int CNT_W = PCTL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RAW-1:0]   id_rs1_addr,
  input  logic [RAW-1:0]   id_rs2_addr,
  input  logic             id_rs1_cen,
  input  logic             id_rs2_cen,
  input  logic             id_jump,
  input  logic [RAW-1:0]   ex_rd_addr,
  input  logic             ex_rd_wen,
  input  logic             ex_mem_read,
  input  logic [RAW-1:0]   ls_rd_addr,
  input  logic             ls_rd_wen,
  input  logic             if_busy,
  input  logic             ls_busy,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_pc,
  input  logic             if_redir_rdy,
  output logic             fwd_ex_rs1,
  output logic             fwd_ex_rs2,
  output logic             fwd_ls_rs1,
  output logic             fwd_ls_rs2,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_ls_stall,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  pctl_state_t     state_q;
  pctl_state_t     state_d;
  logic            pend_q;
  logic            pend_d;
  logic            rv_q;
  logic            rv_d;
  logic [XLEN-1:0] rpc_q;
  logic [XLEN-1:0] rpc_d;
  logic [CNT_W-1:0] cnt_q;

  logic f_ex1;
  logic f_ex2;
  logic f_ls1;
  logic f_ls2;
  logic lu;
  logic busy;

  logic pcs_c;
  logic ifs_c;
  logic flu_c;
  logic bub_c;
  logic exs_c;

  pctl_fwd_unit #(
    .RAW (RAW)
  ) u_fwd (
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_cen  (id_rs1_cen),
    .id_rs2_cen  (id_rs2_cen),
    .ex_rd_addr  (ex_rd_addr),
    .ex_rd_wen   (ex_rd_wen),
    .ex_mem_read (ex_mem_read),
    .ls_rd_addr  (ls_rd_addr),
    .ls_rd_wen   (ls_rd_wen),
    .fwd_ex_rs1  (f_ex1),
    .fwd_ex_rs2  (f_ex2),
    .fwd_ls_rs1  (f_ls1),
    .fwd_ls_rs2  (f_ls2),
    .lu          (lu)
  );

  assign busy = if_busy | ls_busy;

  // State, redirect target and pending-trap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PCTL_RUN;
      pend_q  <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  // Next state and stall/flush controls by priority:
  // trap, bus wait, load-use, jump.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    pcs_c   = 1'b0;
    ifs_c   = 1'b0;
    flu_c   = 1'b0;
    bub_c   = 1'b0;
    exs_c   = 1'b0;
    unique case (state_q)
      PCTL_RUN: begin
        unique case (1'b1)
          trap_req: begin
            rpc_d   = trap_pc;
            rv_d    = 1'b1;
            state_d = PCTL_REDIR;
            pcs_c   = 1'b1;
            ifs_c   = 1'b1;
          end
          (!trap_req && busy): begin
            state_d = PCTL_MWAIT;
            pcs_c   = 1'b1;
            ifs_c   = 1'b1;
            exs_c   = 1'b1;
          end
          (!trap_req && !busy && lu): begin
            pcs_c = 1'b1;
            ifs_c = 1'b1;
            bub_c = 1'b1;
          end
          (!trap_req && !busy && !lu): begin
            flu_c = id_jump;
          end
        endcase
      end
      PCTL_MWAIT: begin
        if (trap_req) begin
          rpc_d  = trap_pc;
          pend_d = 1'b1;
        end
        unique case (1'b1)
          busy: begin
            pcs_c = 1'b1;
            ifs_c = 1'b1;
            exs_c = 1'b1;
          end
          (!busy && (pend_q || trap_req)): begin
            pend_d  = 1'b0;
            rv_d    = 1'b1;
            state_d = PCTL_REDIR;
            pcs_c   = 1'b1;
            ifs_c   = 1'b1;
          end
          (!busy && !pend_q && !trap_req): begin
            state_d = PCTL_RUN;
            if (lu) begin
              pcs_c = 1'b1;
              ifs_c = 1'b1;
              bub_c = 1'b1;
            end else begin
              flu_c = id_jump;
            end
          end
        endcase
      end
      PCTL_REDIR: begin
        pcs_c = 1'b1;
        flu_c = 1'b1;
        bub_c = 1'b1;
        if (trap_req) begin
          rpc_d = trap_pc;
        end else if (if_redir_rdy) begin
          rv_d    = 1'b0;
          state_d = PCTL_RUN;
        end
      end
      default: begin
        state_d = PCTL_RUN;
        pend_d  = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  // Count every cycle in which the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (pc_stall) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fwd_ex_rs1   = rst_n & f_ex1;
  assign fwd_ex_rs2   = rst_n & f_ex2;
  assign fwd_ls_rs1   = rst_n & f_ls1;
  assign fwd_ls_rs2   = rst_n & f_ls2;
  assign pc_stall     = rst_n & pcs_c;
  assign if_id_stall  = rst_n & ifs_c;
  assign if_id_flush  = rst_n & flu_c;
  assign id_ex_bubble = rst_n & bub_c;
  assign ex_ls_stall  = rst_n & exs_c;
  assign redir_valid  = rv_q;
  assign redir_pc     = rpc_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level
// reference model checked on every falling edge.
module tb_pipe_ctrl;

  localparam int XLEN  = 64;
  localparam int RAW   = 5;
  localparam int CNT_W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [RAW-1:0]  id_rs1_addr;
  logic [RAW-1:0]  id_rs2_addr;
  logic            id_rs1_cen;
  logic            id_rs2_cen;
  logic            id_jump;
  logic [RAW-1:0]  ex_rd_addr;
  logic            ex_rd_wen;
  logic            ex_mem_read;
  logic [RAW-1:0]  ls_rd_addr;
  logic            ls_rd_wen;
  logic            if_busy;
  logic            ls_busy;
  logic            trap_req;
  logic [XLEN-1:0] trap_pc;
  logic            if_redir_rdy;

  logic             fwd_ex_rs1;
  logic             fwd_ex_rs2;
  logic             fwd_ls_rs1;
  logic             fwd_ls_rs2;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_ls_stall;
  logic             redir_valid;
  logic [XLEN-1:0]  redir_pc;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(
    .XLEN  (XLEN),
    .RAW   (RAW),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_cen   (id_rs1_cen),
    .id_rs2_cen   (id_rs2_cen),
    .id_jump      (id_jump),
    .ex_rd_addr   (ex_rd_addr),
    .ex_rd_wen    (ex_rd_wen),
    .ex_mem_read  (ex_mem_read),
    .ls_rd_addr   (ls_rd_addr),
    .ls_rd_wen    (ls_rd_wen),
    .if_busy      (if_busy),
    .ls_busy      (ls_busy),
    .trap_req     (trap_req),
    .trap_pc      (trap_pc),
    .if_redir_rdy (if_redir_rdy),
    .fwd_ex_rs1   (fwd_ex_rs1),
    .fwd_ex_rs2   (fwd_ex_rs2),
    .fwd_ls_rs1   (fwd_ls_rs1),
    .fwd_ls_rs2   (fwd_ls_rs2),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_ls_stall  (ex_ls_stall),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model: which cause owns the cycle,
  // plus redirect bookkeeping.
  logic             m_pres;
  logic             m_pend;
  logic             m_wait;
  logic [XLEN-1:0]  m_tgt;
  logic [CNT_W-1:0] m_cnt;

  logic e1, e2, l1, l2, lu_m, busy_m, take_m;
  int   why;
  logic x_pcs, x_ifs, x_flu, x_bub, x_exs;
  logic x_fe1, x_fe2, x_fl1, x_fl2;

  always_comb begin
    e1 = id_rs1_cen && id_rs1_addr != 0 && ex_rd_wen
         && ex_rd_addr == id_rs1_addr;
    e2 = id_rs2_cen && id_rs2_addr != 0 && ex_rd_wen
         && ex_rd_addr == id_rs2_addr;
    l1 = id_rs1_cen && id_rs1_addr != 0 && ls_rd_wen
         && ls_rd_addr == id_rs1_addr;
    l2 = id_rs2_cen && id_rs2_addr != 0 && ls_rd_wen
         && ls_rd_addr == id_rs2_addr;
    lu_m   = id_valid && ex_mem_read && (e1 || e2);
    busy_m = if_busy || ls_busy;
    take_m = m_wait ? (!busy_m && (m_pend || trap_req))
                    : (!m_pres && trap_req);
    why = 0;
    if (!rst_n)       why = 0;
    else if (m_pres)  why = 1;
    else if (take_m)  why = 2;
    else if (busy_m)  why = 3;
    else if (lu_m)    why = 4;
    else if (id_jump) why = 5;
    x_pcs = why >= 1 && why <= 4;
    x_ifs = why >= 2 && why <= 4;
    x_flu = why == 1 || why == 5;
    x_bub = why == 1 || why == 4;
    x_exs = why == 3;
    x_fe1 = rst_n && e1 && !ex_mem_read;
    x_fe2 = rst_n && e2 && !ex_mem_read;
    x_fl1 = rst_n && l1 && !e1;
    x_fl2 = rst_n && l2 && !e2;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pres <= 1'b0;
      m_pend <= 1'b0;
      m_wait <= 1'b0;
      m_tgt  <= '0;
      m_cnt  <= '0;
    end else begin
      m_cnt <= m_cnt + CNT_W'(x_pcs);
      if (m_pres) begin
        if (trap_req) m_tgt <= trap_pc;
        else if (if_redir_rdy) m_pres <= 1'b0;
      end else if (m_wait) begin
        if (trap_req) begin
          m_tgt  <= trap_pc;
          m_pend <= 1'b1;
        end
        if (!busy_m) begin
          m_wait <= 1'b0;
          if (m_pend || trap_req) begin
            m_pres <= 1'b1;
            m_pend <= 1'b0;
          end
        end
      end else if (trap_req) begin
        m_tgt  <= trap_pc;
        m_pres <= 1'b1;
      end else if (busy_m) begin
        m_wait <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_fwd_ex_rs1", 64'(fwd_ex_rs1), 64'(x_fe1));
    chk("m_fwd_ex_rs2", 64'(fwd_ex_rs2), 64'(x_fe2));
    chk("m_fwd_ls_rs1", 64'(fwd_ls_rs1), 64'(x_fl1));
    chk("m_fwd_ls_rs2", 64'(fwd_ls_rs2), 64'(x_fl2));
    chk("m_pc_stall", 64'(pc_stall), 64'(x_pcs));
    chk("m_if_id_stall", 64'(if_id_stall), 64'(x_ifs));
    chk("m_if_id_flush", 64'(if_id_flush), 64'(x_flu));
    chk("m_id_ex_bubble", 64'(id_ex_bubble), 64'(x_bub));
    chk("m_ex_ls_stall", 64'(ex_ls_stall), 64'(x_exs));
    chk("m_redir_valid", 64'(redir_valid), 64'(m_pres));
    chk("m_redir_pc", redir_pc, m_tgt);
    chk("m_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  end

  task automatic clr();
    id_valid     = 1'b0;
    id_rs1_addr  = '0;
    id_rs2_addr  = '0;
    id_rs1_cen   = 1'b0;
    id_rs2_cen   = 1'b0;
    id_jump      = 1'b0;
    ex_rd_addr   = '0;
    ex_rd_wen    = 1'b0;
    ex_mem_read  = 1'b0;
    ls_rd_addr   = '0;
    ls_rd_wen    = 1'b0;
    if_busy      = 1'b0;
    ls_busy      = 1'b0;
    trap_req     = 1'b0;
    trap_pc      = '0;
    if_redir_rdy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [4:0] r1,
                        input logic [4:0] r2);
    id_valid    = 1'b1;
    id_rs1_addr = r1;
    id_rs2_addr = r2;
    id_rs1_cen  = 1'b1;
    id_rs2_cen  = 1'b1;
  endtask

  task automatic set_ex(input logic [4:0] rd,
                        input logic ld);
    ex_rd_addr  = rd;
    ex_rd_wen   = 1'b1;
    ex_mem_read = ld;
  endtask

  task automatic set_ls(input logic [4:0] rd);
    ls_rd_addr = rd;
    ls_rd_wen  = 1'b1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    set_id(5'd5, 5'd0);
    set_ex(5'd5, 1'b0);
    smp();
    chk("rst_fwd_ex_rs1", 64'(fwd_ex_rs1), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_redir_pc", redir_pc, 64'd0);
    tick();
    rst_n = 1'b1;
    clr();

    // add x5 in EX, beq x5,x0 in ID
    tick();
    set_id(5'd5, 5'd0);
    set_ex(5'd5, 1'b0);
    smp();
    chk("beq_fwd_ex_rs1", 64'(fwd_ex_rs1), 64'd1);
    chk("beq_pc_stall", 64'(pc_stall), 64'd0);
    chk("beq_cnt", 64'(stall_cnt), 64'd0);

    // ld x6 in EX, add x7,x6,x1 in ID
    tick();
    clr();
    set_id(5'd6, 5'd1);
    set_ex(5'd6, 1'b1);
    smp();
    chk("lu_pc_stall", 64'(pc_stall), 64'd1);
    chk("lu_bubble", 64'(id_ex_bubble), 64'd1);
    chk("lu_fwd_ex_rs1", 64'(fwd_ex_rs1), 64'd0);
    chk("lu_cnt0", 64'(stall_cnt), 64'd0);
    tick();
    clr();
    set_id(5'd6, 5'd1);
    set_ls(5'd6);
    smp();
    chk("lu_fwd_ls_rs1", 64'(fwd_ls_rs1), 64'd1);
    chk("lu_after_stall", 64'(pc_stall), 64'd0);
    chk("lu_cnt1", 64'(stall_cnt), 64'd1);

    // load to x0, ID reads x0
    tick();
    clr();
    set_id(5'd0, 5'd0);
    set_ex(5'd0, 1'b1);
    set_ls(5'd0);
    smp();
    chk("x0_fwd_ex_rs1", 64'(fwd_ex_rs1), 64'd0);
    chk("x0_fwd_ls_rs1", 64'(fwd_ls_rs1), 64'd0);
    chk("x0_pc_stall", 64'(pc_stall), 64'd0);

    // EX and LS both write x8, rs2=x8
    tick();
    clr();
    set_id(5'd3, 5'd8);
    set_ex(5'd8, 1'b0);
    set_ls(5'd8);
    smp();
    chk("x8_fwd_ex_rs2", 64'(fwd_ex_rs2), 64'd1);
    chk("x8_fwd_ls_rs2", 64'(fwd_ls_rs2), 64'd0);
    tick();
    ex_rd_wen = 1'b0;
    smp();
    chk("x8_ls_only", 64'(fwd_ls_rs2), 64'd1);

    // ls_busy 3 cycles with load-use pending
    for (int i = 0; i < 3; i++) begin
      tick();
      clr();
      set_id(5'd6, 5'd1);
      set_ex(5'd6, 1'b1);
      ls_busy = 1'b1;
      smp();
      chk("mw_pc_stall", 64'(pc_stall), 64'd1);
      chk("mw_bubble", 64'(id_ex_bubble), 64'd0);
      chk("mw_ex_ls_stall", 64'(ex_ls_stall), 64'd1);
    end
    tick();
    ls_busy = 1'b0;
    smp();
    chk("mw_lu_bubble", 64'(id_ex_bubble), 64'd1);
    chk("mw_lu_exls", 64'(ex_ls_stall), 64'd0);
    chk("mw_cnt_mid", 64'(stall_cnt), 64'd4);
    tick();
    clr();
    set_id(5'd6, 5'd1);
    set_ls(5'd6);
    smp();
    chk("mw_cnt_end", 64'(stall_cnt), 64'd5);
    chk("mw_fwd_ls_rs1", 64'(fwd_ls_rs1), 64'd1);

    // jump alone, then jump with load-use
    tick();
    clr();
    set_id(5'd2, 5'd3);
    id_jump = 1'b1;
    smp();
    chk("jmp_flush", 64'(if_id_flush), 64'd1);
    chk("jmp_pc_stall", 64'(pc_stall), 64'd0);
    tick();
    set_ex(5'd2, 1'b1);
    smp();
    chk("jlu_flush", 64'(if_id_flush), 64'd0);
    chk("jlu_bubble", 64'(id_ex_bubble), 64'd1);
    tick();
    ex_rd_wen   = 1'b0;
    ex_mem_read = 1'b0;
    set_ls(5'd2);
    smp();
    chk("jlu_reeval", 64'(if_id_flush), 64'd1);
    chk("jlu_cnt", 64'(stall_cnt), 64'd6);

    // trap during instruction-bus wait
    tick();
    clr();
    if_busy = 1'b1;
    tick();
    trap_req = 1'b1;
    trap_pc  = 64'h8000_0100;
    smp();
    chk("tr_wait_valid", 64'(redir_valid), 64'd0);
    tick();
    clr();
    smp();
    chk("tr_idle_stall", 64'(pc_stall), 64'd1);
    chk("tr_idle_valid", 64'(redir_valid), 64'd0);
    tick();
    if_redir_rdy = 1'b1;
    smp();
    chk("tr_valid", 64'(redir_valid), 64'd1);
    chk("tr_pc", redir_pc, 64'h8000_0100);
    chk("tr_flush", 64'(if_id_flush), 64'd1);
    tick();
    clr();
    smp();
    chk("tr_drop", 64'(redir_valid), 64'd0);
    chk("tr_cnt", 64'(stall_cnt), 64'd10);

    // reset asserted while redirect is pending
    tick();
    trap_req = 1'b1;
    trap_pc  = 64'h1234;
    tick();
    clr();
    smp();
    chk("rr_valid", 64'(redir_valid), 64'd1);
    chk("rr_pc", redir_pc, 64'h1234);
    tick();
    rst_n = 1'b0;
    smp();
    chk("rr_rst_valid", 64'(redir_valid), 64'd0);
    chk("rr_rst_pc", redir_pc, 64'd0);
    chk("rr_rst_flush", 64'(if_id_flush), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    smp();
    chk("rr_after", 64'(redir_valid), 64'd0);
    chk("rr_cnt", 64'(stall_cnt), 64'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
